// File: rtl/systolic_tile_scheduler.sv
// Splits one m_tiles x n_tiles GEMM into single-tile core commands, one tile in flight,
// walking addresses with running pointers and reporting tile count and elapsed cycles.
module systolic_tile_scheduler #(
    parameter int unsigned SYSTOLIC_ARRAY_DIM = 8,
    parameter int unsigned DATA_WIDTH_BITS    = 16,
    parameter int unsigned ADDR_BITS          = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_BITS-1:0] cmd_act_base,
    input  logic [ADDR_BITS-1:0] cmd_wgt_base,
    input  logic [ADDR_BITS-1:0] cmd_out_base,
    input  logic [15:0]          cmd_m_tiles,
    input  logic [15:0]          cmd_n_tiles,
    input  logic [19:0]          cmd_inner_dimension,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_tile_count,
    output logic [31:0]          resp_cycles,
    output logic                 core_cmd_valid,
    input  logic                 core_cmd_ready,
    output logic [ADDR_BITS-1:0] core_act_addr,
    output logic [ADDR_BITS-1:0] core_wgt_addr,
    output logic [ADDR_BITS-1:0] core_out_addr,
    output logic [19:0]          core_inner_dimension,
    input  logic                 core_resp_valid,
    output logic                 core_resp_ready,
    output logic                 busy
);

    localparam int unsigned BYTES    = DATA_WIDTH_BITS / 8;
    localparam int unsigned TS_SCALE = BYTES * SYSTOLIC_ARRAY_DIM;
    localparam int unsigned OS_BYTES = SYSTOLIC_ARRAY_DIM * SYSTOLIC_ARRAY_DIM * BYTES;
    localparam logic [ADDR_BITS-1:0] OS = ADDR_BITS'(OS_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                 cmd_ready_q, cmd_ready_d;
    logic                 core_cmd_valid_q, core_cmd_valid_d;
    logic                 core_resp_ready_q, core_resp_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 busy_q, busy_d;

    logic [15:0]          m_q, n_q, i_q, j_q;
    logic [19:0]          k_q;
    logic [ADDR_BITS-1:0] ts_q, wgt_base_q;
    logic [ADDR_BITS-1:0] act_ptr_q, wgt_ptr_q, out_ptr_q;
    logic [31:0]          count_q, cycles_q;

    logic accept_c, core_cmd_fire_c, core_resp_fire_c, resp_fire_c;
    logic zero_size_c, last_tile_c, row_end_c;

    assign accept_c         = cmd_valid && cmd_ready_q;
    assign core_cmd_fire_c  = core_cmd_valid_q && core_cmd_ready;
    assign core_resp_fire_c = core_resp_valid && core_resp_ready_q;
    assign resp_fire_c      = resp_valid_q && resp_ready;
    assign zero_size_c      = (cmd_m_tiles == 16'd0) || (cmd_n_tiles == 16'd0)
                              || (cmd_inner_dimension == 20'd0);
    assign row_end_c        = (j_q == n_q - 16'd1);
    assign last_tile_c      = row_end_c && (i_q == m_q - 16'd1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept_c) state_d = zero_size_c ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (core_cmd_fire_c) state_d = ST_WAIT;
            ST_WAIT:  if (core_resp_fire_c) state_d = last_tile_c ? ST_DONE : ST_ISSUE;
            ST_DONE:  if (resp_fire_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they flop alongside it
    always_comb begin
        cmd_ready_d       = 1'b0;
        core_cmd_valid_d  = 1'b0;
        core_resp_ready_d = 1'b0;
        resp_valid_d      = 1'b0;
        busy_d            = 1'b1;
        unique case (state_d)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            ST_ISSUE: core_cmd_valid_d  = 1'b1;
            ST_WAIT:  core_resp_ready_d = 1'b1;
            ST_DONE:  resp_valid_d      = 1'b1;
            default:  busy_d            = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_ready_q       <= 1'b1;
            core_cmd_valid_q  <= 1'b0;
            core_resp_ready_q <= 1'b0;
            resp_valid_q      <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            cmd_ready_q       <= cmd_ready_d;
            core_cmd_valid_q  <= core_cmd_valid_d;
            core_resp_ready_q <= core_resp_ready_d;
            resp_valid_q      <= resp_valid_d;
            busy_q            <= busy_d;
        end
    end

    // Tile walk: j inner, i outer; pointers advance by adds only
    always_ff @(posedge clock) begin
        if (reset) begin
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            ts_q       <= '0;
            wgt_base_q <= '0;
            act_ptr_q  <= '0;
            wgt_ptr_q  <= '0;
            out_ptr_q  <= '0;
            count_q    <= '0;
            cycles_q   <= '0;
        end else if (accept_c) begin
            m_q        <= cmd_m_tiles;
            n_q        <= cmd_n_tiles;
            k_q        <= cmd_inner_dimension;
            i_q        <= '0;
            j_q        <= '0;
            ts_q       <= ADDR_BITS'(cmd_inner_dimension) * ADDR_BITS'(TS_SCALE);
            wgt_base_q <= cmd_wgt_base;
            act_ptr_q  <= cmd_act_base;
            wgt_ptr_q  <= cmd_wgt_base;
            out_ptr_q  <= cmd_out_base;
            count_q    <= '0;
            cycles_q   <= '0;
        end else begin
            if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (cycles_q != 32'hFFFF_FFFF)) begin
                cycles_q <= cycles_q + 32'd1;
            end
            if ((state_q == ST_WAIT) && core_resp_fire_c) begin
                count_q   <= count_q + 32'd1;
                out_ptr_q <= out_ptr_q + OS;
                if (!row_end_c) begin
                    j_q       <= j_q + 16'd1;
                    wgt_ptr_q <= wgt_ptr_q + ts_q;
                end else begin
                    j_q       <= '0;
                    wgt_ptr_q <= wgt_base_q;
                    i_q       <= i_q + 16'd1;
                    act_ptr_q <= act_ptr_q + ts_q;
                end
            end
        end
    end

    assign cmd_ready            = cmd_ready_q;
    assign core_cmd_valid       = core_cmd_valid_q;
    assign core_resp_ready      = core_resp_ready_q;
    assign resp_valid           = resp_valid_q;
    assign busy                 = busy_q;
    assign core_act_addr        = act_ptr_q;
    assign core_wgt_addr        = wgt_ptr_q;
    assign core_out_addr        = out_ptr_q;
    assign core_inner_dimension = k_q;
    assign resp_tile_count      = count_q;
    assign resp_cycles          = cycles_q;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler: a table of GEMM commands with hand-computed
// tile counts and cycle totals, plus a mid-operation reset sequence.
module tb_systolic_tile_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [63:0] cmd_act_base, cmd_wgt_base, cmd_out_base;
    logic [15:0] cmd_m_tiles, cmd_n_tiles;
    logic [19:0] cmd_inner_dimension;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_tile_count, resp_cycles;
    logic        core_cmd_valid, core_cmd_ready;
    logic [63:0] core_act_addr, core_wgt_addr, core_out_addr;
    logic [19:0] core_inner_dimension;
    logic        core_resp_valid, core_resp_ready;
    logic        busy;

    int vecs = 0;
    int fails = 0;

    always #5 clock = ~clock;

    systolic_tile_scheduler dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_act_base(cmd_act_base), .cmd_wgt_base(cmd_wgt_base), .cmd_out_base(cmd_out_base),
        .cmd_m_tiles(cmd_m_tiles), .cmd_n_tiles(cmd_n_tiles),
        .cmd_inner_dimension(cmd_inner_dimension),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_tile_count(resp_tile_count), .resp_cycles(resp_cycles),
        .core_cmd_valid(core_cmd_valid), .core_cmd_ready(core_cmd_ready),
        .core_act_addr(core_act_addr), .core_wgt_addr(core_wgt_addr), .core_out_addr(core_out_addr),
        .core_inner_dimension(core_inner_dimension),
        .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
        .busy(busy)
    );

    // One GEMM command: sizes, bases, stall profile (cl: core_cmd_ready low cycles,
    // rd: core response delay, rh: resp_ready hold-off), spurious core_resp in ISSUE,
    // and the hand-computed response (cycles = tiles * (2 + cl + rd)).
    typedef struct {
        int          m, n, k;
        logic [63:0] act, wgt, out;
        int          cl, rd, rh;
        bit          spurious;
        int          exp_count;
        int          exp_cycles;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vecs++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic chk_addrs(input string tag, input vec_t v, input int i, input int j);
        logic [63:0] ts;
        ts = 64'(v.k) * 64'd16;
        chk({tag, "_act"}, core_act_addr, v.act + 64'(i) * ts);
        chk({tag, "_wgt"}, core_wgt_addr, v.wgt + 64'(j) * ts);
        chk({tag, "_out"}, core_out_addr, v.out + 64'(i * v.n + j) * 64'd128);
        chk({tag, "_k"}, 64'(core_inner_dimension), 64'(v.k));
    endtask

    // Runs one command; abort_tile >= 0 resets the DUT while that tile is in WAIT.
    task automatic run_vec(input vec_t v, input int abort_tile);
        int tiles;
        tiles = (v.k == 0) ? 0 : v.m * v.n;
        cmd_valid           = 1'b1;
        cmd_act_base        = v.act;
        cmd_wgt_base        = v.wgt;
        cmd_out_base        = v.out;
        cmd_m_tiles         = 16'(v.m);
        cmd_n_tiles         = 16'(v.n);
        cmd_inner_dimension = 20'(v.k);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("cmd_ready_after_accept", 64'(cmd_ready), 64'd0);
        for (int t = 0; t < tiles; t++) begin
            chk("issue_valid", 64'(core_cmd_valid), 64'd1);
            chk_addrs("issue", v, t / v.n, t % v.n);
            for (int s = 0; s < v.cl; s++) begin
                if (v.spurious && s == 0) begin
                    core_resp_valid = 1'b1;
                    chk("resp_ready_in_issue", 64'(core_resp_ready), 64'd0);
                end
                @(negedge clock);
                core_resp_valid = 1'b0;
                chk("stall_valid", 64'(core_cmd_valid), 64'd1);
                if (s == v.cl - 1) chk_addrs("stall", v, t / v.n, t % v.n);
            end
            core_cmd_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            core_cmd_ready = 1'b0;
            chk("cmd_drop", 64'(core_cmd_valid), 64'd0);
            chk("wait_resp_ready", 64'(core_resp_ready), 64'd1);
            if (t == abort_tile) begin
                reset = 1'b1;
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
                chk("abort_core_cmd_valid", 64'(core_cmd_valid), 64'd0);
                chk("abort_resp_valid", 64'(resp_valid), 64'd0);
                chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_core_resp_ready", 64'(core_resp_ready), 64'd0);
                return;
            end
            repeat (v.rd) @(negedge clock);
            core_resp_valid = 1'b1;
            @(posedge clock);
            @(negedge clock);
            core_resp_valid = 1'b0;
            chk("post_resp_ready_low", 64'(core_resp_ready), 64'd0);
        end
        chk("done_resp_valid", 64'(resp_valid), 64'd1);
        chk("done_core_cmd_valid", 64'(core_cmd_valid), 64'd0);
        chk("done_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("done_count", 64'(resp_tile_count), 64'(v.exp_count));
        chk("done_cycles", 64'(resp_cycles), 64'(v.exp_cycles));
        for (int h = 0; h < v.rh; h++) begin
            @(negedge clock);
            chk("hold_resp_valid", 64'(resp_valid), 64'd1);
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("hold_count", 64'(resp_tile_count), 64'(v.exp_count));
            chk("hold_cycles", 64'(resp_cycles), 64'(v.exp_cycles));
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        chk("idle_resp_valid", 64'(resp_valid), 64'd0);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va;
        tbl[0] = '{1, 1, 4, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, 1'b0, 1, 2};
        tbl[1] = '{2, 3, 4, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, 1'b0, 6, 12};
        tbl[2] = '{0, 5, 4, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, 1'b0, 0, 0};
        tbl[3] = '{1, 2, 4, 64'h1000, 64'h2000, 64'h3000, 5, 10, 3, 1'b0, 2, 34};
        tbl[4] = '{2, 2, 4, 64'h1000, 64'h2000, 64'h3000, 2, 1, 0, 1'b1, 4, 20};
        tbl[5] = '{2, 1, 4, 64'hFFFF_FFFF_FFFF_FFC0, 64'h2000, 64'hFFFF_FFFF_FFFF_FF80,
                   0, 0, 0, 1'b0, 2, 4};
        tbl[6] = '{3, 0, 4, 64'h1000, 64'h2000, 64'h3000, 0, 0, 1, 1'b0, 0, 0};
        tbl[7] = '{1, 1, 0, 64'h1000, 64'h2000, 64'h3000, 0, 0, 0, 1'b0, 0, 0};

        reset               = 1'b1;
        cmd_valid           = 1'b0;
        cmd_act_base        = '0;
        cmd_wgt_base        = '0;
        cmd_out_base        = '0;
        cmd_m_tiles         = '0;
        cmd_n_tiles         = '0;
        cmd_inner_dimension = '0;
        resp_ready          = 1'b0;
        core_cmd_ready      = 1'b0;
        core_resp_valid     = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_core_cmd_valid", 64'(core_cmd_valid), 64'd0);
        chk("reset_core_resp_ready", 64'(core_resp_ready), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_count", 64'(resp_tile_count), 64'd0);
        chk("reset_cycles", 64'(resp_cycles), 64'd0);

        for (int v = 0; v < 8; v++) begin
            run_vec(tbl[v], -1);
            @(negedge clock);
        end

        // Reset while the second of six tiles is outstanding, then restart from tile (0,0)
        run_vec(tbl[1], 1);
        @(negedge clock);
        va = '{1, 1, 4, 64'h5000, 64'h6000, 64'h7000, 0, 0, 0, 1'b0, 1, 2};
        run_vec(va, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
